ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17: data RAM byte-address width.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter LOCK_MAX, default 16: maximum consecutive locked grants to one port.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Ports p0_req / p1_req, input, 1 each: port 0 (core load/store) and port 1 (loader) access request.
REQ-007 Ports pN_we, input, 1: write request (1) or read request (0).
REQ-008 Ports pN_lock, input, 1: keep the grant on the next cycle.
REQ-009 Ports pN_addr, input, ADDR_W: byte address.
REQ-010 Ports pN_wdata, input, DATA_W: write data.
REQ-011 Ports pN_dtype, input, 2: access size code, passed through to RAM unchanged.
REQ-012 Ports pN_gnt, output, 1: access accepted this cycle.
REQ-013 Ports pN_rvalid, output, 1: pN_rdata valid.
REQ-014 Ports pN_rdata, output, DATA_W: read data.
REQ-015 Ports ram_we (1), ram_addr (ADDR_W), ram_wd (DATA_W), ram_dtype (2), outputs: shared RAM port.
REQ-016 Port ram_rd, input, DATA_W: combinational RAM read data.

Function
REQ-017 Handshake: requester holds req, we, addr, wdata and dtype stable until it samples gnt=1; the access completes in the gnt cycle.
REQ-018 At most one gnt per cycle; gnt is combinational from req and registered state.
REQ-019 RAM port is muxed from the granted port; ram_we = granted pN_we & pN_req; with no grant, ram_we=0 and addr/wd/dtype=0.
REQ-020 Read: ram_rd is captured on the gnt edge; pN_rvalid=1 for exactly the next cycle with pN_rdata held until that port's next read capture.
REQ-021 Write: commits on the gnt edge; no rvalid is generated.
REQ-022 Arbitration: a single requester is granted immediately; when both request, the port not granted most recently (register last_gnt) wins.
REQ-023 Lock: when the granted port has lock=1, it owns the next cycle (FSM state LOCK0/LOCK1 from IDLE); the other port's gnt=0 during ownership even if the owner has req=0.
REQ-024 States: IDLE, LOCK0, LOCK1. IDLE->LOCKn on a grant to n with pN_lock=1; LOCKn->IDLE when pN_lock=0 on a grant or pN_req=0.
REQ-025 Lock counter lock_cnt increments on each locked grant. When lock_cnt reaches LOCK_MAX-1 and the other port requests, state->IDLE with last_gnt=owner, so the other port wins next; the counter clears on leaving LOCKn.
REQ-026 Address and data pass through unmodified; no alignment checks are made (RAM handles dtype).

Reset
REQ-027 On rst: state=IDLE, last_gnt=1 (port 0 wins the first tie), lock_cnt=0, pN_rvalid=0, pN_rdata=0.
REQ-028 rst during a locked sequence: lock released immediately; a capture pending for the reset cycle is discarded (rvalid stays 0).
REQ-029 gnt outputs are 0 while rst is high.

Configuration
REQ-030 Macro RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins ties, and last_gnt is unused; lock and LOCK_MAX limits still apply.
REQ-031 Macro absent: round-robin per REQ-022.

Structure
REQ-032 Shared package cpu_pkg holds the arb_state_t enum (IDLE, LOCK0, LOCK1), dtype encodings, and the DATA_W/ADDR_W defaults.
REQ-033 One sub-module, arb_port_mux: combinational selection of the RAM signals from the granted port; the FSM, counter and read capture live in ram_arbiter.

Verification
REQ-034 After reset, p0 and p1 both read (p0 addr 0x10, p1 addr 0x20) in the same cycle -> p0_gnt first, p1_gnt next cycle; rvalid follows each grant by 1 cycle.
REQ-035 p1 writes 0xDEADBEEF to 0x40, then p0 reads 0x40 -> p0_rdata=0xDEADBEEF with p0_rvalid=1 one cycle after p0_gnt.
REQ-036 p1 holds lock=1 and req=1 for 20 cycles while p0 requests continuously -> p1 gets 16 grants, then p0_gnt=1, with no cycle having two grants.
REQ-037 Assert rst in the second cycle of a p0 lock -> gnt=0 and rvalid=0 immediately; after release, p1 alone requests -> p1_gnt=1 on the first cycle.
REQ-038 Build with RAM_ARB_FIXED_PRIO_EN and have both ports request for 4 cycles -> p0_gnt=1 every cycle and p1_gnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared arbiter state type, access size codes and bus width defaults
package cpu_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_port_mux.sv
// rtl/arb_port_mux.sv - steers the shared RAM port from whichever requester holds the grant
module arb_port_mux #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              gnt0,
    input  logic              gnt1,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_dtype,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_dtype,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wd,
    output logic [1:0]        ram_dtype
);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wd    = '0;
        ram_dtype = 2'b00;
        if (gnt0) begin
            ram_we    = p0_we & p0_req;
            ram_addr  = p0_addr;
            ram_wd    = p0_wdata;
            ram_dtype = p0_dtype;
        end else if (gnt1) begin
            ram_we    = p1_we & p1_req;
            ram_addr  = p1_addr;
            ram_wd    = p1_wdata;
            ram_dtype = p1_dtype;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port data RAM arbiter with lock ownership and read capture
// RAM_ARB_FIXED_PRIO_EN: port 0 wins every tie instead of round-robin.
module ram_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_dtype,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_dtype,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wd,
    output logic [1:0]        ram_dtype,
    input  logic [DATA_W-1:0] ram_rd
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state, state_n;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_n;
    logic             gnt0, gnt1;
    logic             tie_p0;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign tie_p0 = 1'b1;
`else
    logic last_gnt, last_gnt_n;
    // last_gnt=1 means port 1 was served most recently, so port 0 takes the tie
    assign tie_p0 = last_gnt;
`endif

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_n    = state;
        lock_cnt_n = lock_cnt;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (p0_req && p1_req) begin
                        gnt0 = tie_p0;
                        gnt1 = !tie_p0;
                    end else begin
                        gnt0 = p0_req;
                        gnt1 = p1_req;
                    end
                    if ((gnt0 && p0_lock) || (gnt1 && p1_lock)) begin
                        state_n    = gnt0 ? LOCK0 : LOCK1;
                        lock_cnt_n = CNT_ONE;
                    end
                end
                LOCK0: begin
                    gnt0 = p0_req;
                    if (!p0_req || !p0_lock || (lock_cnt == CNT_LAST && p1_req)) begin
                        state_n    = IDLE;
                        lock_cnt_n = '0;
                    end else if (lock_cnt != CNT_LAST) begin
                        lock_cnt_n = lock_cnt + CNT_ONE;
                    end
                end
                LOCK1: begin
                    gnt1 = p1_req;
                    if (!p1_req || !p1_lock || (lock_cnt == CNT_LAST && p0_req)) begin
                        state_n    = IDLE;
                        lock_cnt_n = '0;
                    end else if (lock_cnt != CNT_LAST) begin
                        lock_cnt_n = lock_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    lock_cnt_n = '0;
                end
            endcase
        end
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_gnt_n = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_gnt);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_gnt <= last_gnt_n;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= gnt0 & ~p0_we;
            p1_rvalid <= gnt1 & ~p1_we;
            if (gnt0 && !p0_we) p0_rdata <= ram_rd;
            if (gnt1 && !p1_we) p1_rdata <= ram_rd;
        end
    end

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    arb_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_dtype  (p0_dtype),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_dtype  (p1_dtype),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wd    (ram_wd),
        .ram_dtype (ram_dtype)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter: vector table, corner sequences, random vs reference model
module tb_ram_arbiter;
    import cpu_pkg::*;

    localparam int LOCK_MAX = 16;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [16:0] p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic [1:0]  p0_dtype;
    logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [16:0] p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic [1:0]  p1_dtype;
    logic        ram_we;
    logic [16:0] ram_addr;
    logic [31:0] ram_wd, ram_rd;
    logic [1:0]  ram_dtype;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    logic [31:0] smem [0:63];
    assign ram_rd = mem[ram_addr[7:2]];
    always @(posedge clk) if (ram_we) mem[ram_addr[7:2]] <= ram_wd;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(17), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_dtype(p0_dtype), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_dtype(p1_dtype), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
        .ram_dtype(ram_dtype), .ram_rd(ram_rd)
    );

    logic        s_req [2];
    logic        s_we [2];
    logic        s_lock [2];
    logic [16:0] s_addr [2];
    logic [31:0] s_wdata [2];
    logic [1:0]  s_dtype [2];

    typedef struct {
        logic        r0, w0, l0;
        logic [16:0] a0;
        logic [31:0] d0;
        logic        r1, w1, l1;
        logic [16:0] a1;
        logic [31:0] d1;
        logic        eg0, eg1, ev0, ev1;
        logic [31:0] er0, er1;
        logic        ewe;
        logic [16:0] eaddr;
    } vec_t;

    function automatic vec_t mk(logic r0, logic w0, logic [16:0] a0, logic [31:0] d0,
                                logic r1, logic w1, logic [16:0] a1, logic [31:0] d1,
                                logic eg0, logic eg1, logic ev0, logic ev1,
                                logic [31:0] er0, logic [31:0] er1, logic ewe, logic [16:0] eaddr);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = 1'b0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = 1'b0; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
        v.er0 = er0; v.er1 = er1; v.ewe = ewe; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply();
        p0_req = s_req[0]; p0_we = s_we[0]; p0_lock = s_lock[0];
        p0_addr = s_addr[0]; p0_wdata = s_wdata[0]; p0_dtype = s_dtype[0];
        p1_req = s_req[1]; p1_we = s_we[1]; p1_lock = s_lock[1];
        p1_addr = s_addr[1]; p1_wdata = s_wdata[1]; p1_dtype = s_dtype[1];
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            s_req[p] = 1'b0; s_we[p] = 1'b0; s_lock[p] = 1'b0;
            s_addr[p] = '0; s_wdata[p] = '0; s_dtype[p] = DT_WORD;
        end
        apply();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // reference model: current owner (-1 none), grants in this run, last winner
    int          m_owner, m_run, m_prev;
    logic        m_rv [2];
    logic [31:0] m_rd [2];

    task automatic new_req(input int p, input bit biased);
        s_req[p]   = biased ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0);
        s_we[p]    = $urandom_range(0, 1) == 1;
        s_addr[p]  = 17'({$urandom_range(0, 15), 2'b00});
        s_wdata[p] = $urandom;
        s_dtype[p] = 2'($urandom_range(0, 3));
    endtask

    vec_t tbl [9];

    initial begin
        int p1cnt;
        int w;
        bit biased;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;

        tbl[0] = mk(1, 0, 17'h10, 0, 1, 0, 17'h20, 0, 1, 0, 0, 0, 0, 0, 0, 17'h10);
        tbl[1] = mk(0, 0, 17'h0, 0, 1, 0, 17'h20, 0, 0, 1, 1, 0, 32'h1000_0004, 0, 0, 17'h20);
        tbl[2] = mk(0, 0, 17'h0, 0, 0, 0, 17'h0, 0, 0, 0, 0, 1, 32'h1000_0004, 32'h1000_0008, 0, 17'h0);
        tbl[3] = mk(0, 0, 17'h0, 0, 1, 1, 17'h40, 32'hDEADBEEF, 0, 1, 0, 0, 32'h1000_0004, 32'h1000_0008, 1, 17'h40);
        tbl[4] = mk(1, 0, 17'h40, 0, 0, 0, 17'h0, 0, 1, 0, 0, 0, 32'h1000_0004, 32'h1000_0008, 0, 17'h40);
        tbl[5] = mk(0, 0, 17'h0, 0, 0, 0, 17'h0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h1000_0008, 0, 17'h0);
`ifdef RAM_ARB_FIXED_PRIO_EN
        tbl[6] = mk(1, 0, 17'h10, 0, 1, 0, 17'h20, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h1000_0008, 0, 17'h10);
        tbl[7] = mk(0, 0, 17'h0, 0, 1, 0, 17'h20, 0, 0, 1, 1, 0, 32'h1000_0004, 32'h1000_0008, 0, 17'h20);
        tbl[8] = mk(0, 0, 17'h0, 0, 0, 0, 17'h0, 0, 0, 0, 0, 1, 32'h1000_0004, 32'h1000_0008, 0, 17'h0);
`else
        tbl[6] = mk(1, 0, 17'h10, 0, 1, 0, 17'h20, 0, 0, 1, 0, 0, 32'hDEADBEEF, 32'h1000_0008, 0, 17'h20);
        tbl[7] = mk(1, 0, 17'h10, 0, 0, 0, 17'h0, 0, 1, 0, 0, 1, 32'hDEADBEEF, 32'h1000_0008, 0, 17'h10);
        tbl[8] = mk(0, 0, 17'h0, 0, 0, 0, 17'h0, 0, 0, 0, 1, 0, 32'h1000_0004, 32'h1000_0008, 0, 17'h0);
`endif

        // reset state with both ports requesting
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        s_req[0] = 1'b1; s_req[1] = 1'b1;
        apply();
        #3;
        chk("rst_gnt0", p0_gnt, 0);
        chk("rst_gnt1", p1_gnt, 0);
        chk("rst_rvalid0", p0_rvalid, 0);
        chk("rst_rdata0", p0_rdata, 0);
        chk("rst_ram_we", ram_we, 0);

        // directed vector table
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            s_req[0] = tbl[i].r0; s_we[0] = tbl[i].w0; s_lock[0] = tbl[i].l0;
            s_addr[0] = tbl[i].a0; s_wdata[0] = tbl[i].d0;
            s_req[1] = tbl[i].r1; s_we[1] = tbl[i].w1; s_lock[1] = tbl[i].l1;
            s_addr[1] = tbl[i].a1; s_wdata[1] = tbl[i].d1;
            apply();
            #3;
            chk($sformatf("vec%0d gnt0", i), p0_gnt, tbl[i].eg0);
            chk($sformatf("vec%0d gnt1", i), p1_gnt, tbl[i].eg1);
            chk($sformatf("vec%0d rvalid0", i), p0_rvalid, tbl[i].ev0);
            chk($sformatf("vec%0d rvalid1", i), p1_rvalid, tbl[i].ev1);
            chk($sformatf("vec%0d rdata0", i), p0_rdata, tbl[i].er0);
            chk($sformatf("vec%0d rdata1", i), p1_rdata, tbl[i].er1);
            chk($sformatf("vec%0d ram_we", i), ram_we, tbl[i].ewe);
            chk($sformatf("vec%0d ram_addr", i), ram_addr, tbl[i].eaddr);
        end

        // p1 holds a lock while p0 keeps requesting: 16 p1 grants, then p0
        p1cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            s_req[1] = 1'b1; s_we[1] = 1'b0; s_lock[1] = 1'b1; s_addr[1] = 17'h0;
            s_req[0] = (c >= 1); s_we[0] = 1'b0; s_lock[0] = 1'b0; s_addr[0] = 17'h10;
            apply();
            #3;
            chk($sformatf("lock c%0d single gnt", c), p0_gnt & p1_gnt, 0);
            if (c <= 16) begin
                chk($sformatf("lock c%0d gnt1", c), p1_gnt, (c < 16));
                chk($sformatf("lock c%0d gnt0", c), p0_gnt, (c == 16));
                if (p1_gnt) p1cnt++;
            end
        end
        chk("lock p1 grant count", p1cnt, LOCK_MAX);
        @(posedge clk); #1;
        idle_inputs();

        // both request continuously without lock
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            s_req[0] = 1'b1; s_addr[0] = 17'h10;
            s_req[1] = 1'b1; s_addr[1] = 17'h20;
            apply();
            #3;
            chk($sformatf("tie k%0d gnt0", k), p0_gnt, FIXED ? 1'b1 : (k % 2 == 0));
            chk($sformatf("tie k%0d gnt1", k), p1_gnt, FIXED ? 1'b0 : (k % 2 == 1));
        end

        // reset in the second cycle of a p0 lock
        do_reset();
        @(posedge clk); #1;
        s_req[0] = 1'b1; s_lock[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 17'h10;
        apply();
        #3;
        chk("rstlock first gnt0", p0_gnt, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #3;
        chk("rstlock gnt0", p0_gnt, 0);
        chk("rstlock gnt1", p1_gnt, 0);
        chk("rstlock rvalid0", p0_rvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_req[0] = 1'b0; s_lock[0] = 1'b0;
        s_req[1] = 1'b1; s_we[1] = 1'b0; s_addr[1] = 17'h20;
        apply();
        #3;
        chk("rstlock p1 gnt1", p1_gnt, 1);
        chk("rstlock p1 gnt0", p0_gnt, 0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 64; i++) smem[i] = mem[i];
        m_owner = -1; m_run = 0; m_prev = 1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
        biased = 1'b1;
        new_req(0, biased); new_req(1, biased);
        for (int n = 0; n < 800; n++) begin
            biased = (n % 200) < 120;
            for (int p = 0; p < 2; p++)
                s_lock[p] = biased ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            apply();
            #3;
            w = -1;
            if (m_owner >= 0) begin
                if (s_req[m_owner]) w = m_owner;
            end else if (s_req[0] && s_req[1]) begin
                w = FIXED ? 0 : ((m_prev == 0) ? 1 : 0);
            end else if (s_req[0]) begin
                w = 0;
            end else if (s_req[1]) begin
                w = 1;
            end
            chk($sformatf("rnd%0d gnt0", n), p0_gnt, (w == 0));
            chk($sformatf("rnd%0d gnt1", n), p1_gnt, (w == 1));
            chk($sformatf("rnd%0d ram_we", n), ram_we, (w >= 0) ? s_we[w] : 1'b0);
            chk($sformatf("rnd%0d ram_addr", n), ram_addr, (w >= 0) ? s_addr[w] : 17'h0);
            chk($sformatf("rnd%0d ram_wd", n), ram_wd, (w >= 0) ? s_wdata[w] : 32'h0);
            chk($sformatf("rnd%0d ram_dtype", n), ram_dtype, (w >= 0) ? s_dtype[w] : 2'b00);
            chk($sformatf("rnd%0d rvalid0", n), p0_rvalid, m_rv[0]);
            chk($sformatf("rnd%0d rvalid1", n), p1_rvalid, m_rv[1]);
            chk($sformatf("rnd%0d rdata0", n), p0_rdata, m_rd[0]);
            chk($sformatf("rnd%0d rdata1", n), p1_rdata, m_rd[1]);

            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            if (w >= 0) begin
                m_prev = w;
                if (!s_we[w]) begin
                    m_rv[w] = 1'b1;
                    m_rd[w] = smem[s_addr[w][7:2]];
                end else begin
                    smem[s_addr[w][7:2]] = s_wdata[w];
                end
                if (m_owner < 0) begin
                    if (s_lock[w]) begin
                        m_owner = w;
                        m_run = 1;
                    end
                end else begin
                    m_run++;
                    if (!s_lock[w] || (m_run >= LOCK_MAX && s_req[1 - w])) m_owner = -1;
                end
            end else if (m_owner >= 0) begin
                m_owner = -1;
            end
            for (int p = 0; p < 2; p++)
                if (w == p || !s_req[p]) new_req(p, biased);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
